// File: rtl/axis_y_byte_serializer.sv
// ---------------------------------------------------------------------------
// axis_y_byte_serializer
//
// Takes one wide result word (the flattened y vector) over an AXI-Stream
// slave port and emits it byte by byte, least-significant byte first, over
// an AXI-Stream master port. An optional fixed header byte can precede the
// data bytes of each word. The byte stream is meant for a byte-wide UART
// transmitter.
//
// Parameters:
//   W_IN        input word width in bits (multiple of 8, at least 8)
//   HEADER_EN   1 = send HEADER_BYTE before the data bytes of each word
//   HEADER_BYTE value of the header byte
//
// Ports:
//   clk            single clock, rising edge
//   rst            asynchronous, active-high reset
//   s_axis_tvalid  input word valid
//   s_axis_tready  serializer can take a word (combinational)
//   s_axis_tdata   input word, lane r at bits [32r+31:32r]
//   m_axis_tvalid  output byte valid
//   m_axis_tready  downstream accepts the byte
//   m_axis_tdata   output byte
//   m_axis_tlast   high on the final byte of a word
// ---------------------------------------------------------------------------
module axis_y_byte_serializer #(
    parameter int           W_IN        = 256,
    parameter bit           HEADER_EN   = 1'b1,
    parameter logic [7:0]   HEADER_BYTE = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    input  logic [W_IN-1:0] s_axis_tdata,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic [7:0]      m_axis_tdata,
    output logic            m_axis_tlast
);

    localparam int N_BYTES = W_IN / 8;
    localparam int CNT_W   = $clog2(N_BYTES + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    // First state of a frame depends only on whether a header is configured.
    localparam state_t FIRST_STATE = HEADER_EN ? HDR : DATA;

    state_t            state;
    state_t            state_next;
    logic [W_IN-1:0]   sr;
    logic [CNT_W-1:0]  cnt;

    logic              last_byte;
    logic              s_hs;
    logic              m_hs;
    logic              load;
    logic              shift;

    // -----------------------------------------------------------------------
    // Outputs are decoded from registered state only, so a word accepted at
    // one edge shows its first byte in the very next cycle and the byte
    // holds still for as long as the downstream stalls.
    // -----------------------------------------------------------------------
    assign last_byte     = (state == DATA) && (cnt == LAST_CNT);
    assign m_axis_tvalid = (state != IDLE);
    assign m_axis_tdata  = (state == HDR) ? HEADER_BYTE : sr[7:0];
    assign m_axis_tlast  = last_byte;

    // Ready also opens while the last byte is leaving so frames run
    // back-to-back without a bubble. Held low during reset.
    assign s_axis_tready = !rst && ((state == IDLE) || (last_byte && m_axis_tready));

    assign s_hs = s_axis_tvalid && s_axis_tready;
    assign m_hs = m_axis_tvalid && m_axis_tready;

    // -----------------------------------------------------------------------
    // Next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves a signal unassigned and a latch cannot be inferred.
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;

        case (state)
            IDLE: begin
                if (s_hs) begin
                    load       = 1'b1;
                    state_next = FIRST_STATE;
                end
            end

            HDR: begin
                if (m_hs) begin
                    state_next = DATA;
                end
            end

            DATA: begin
                if (m_hs) begin
                    shift = 1'b1;
                    if (last_byte) begin
                        if (s_hs) begin
                            // New word replaces the spent one; load wins
                            // over shift in the datapath below.
                            load       = 1'b1;
                            state_next = FIRST_STATE;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Shift register and byte counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the shift register is cleared on reset on purpose: its low
        // byte drives m_axis_tdata, which must read zero out of reset.
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= s_axis_tdata;
            cnt <= '0;
        end else if (shift) begin
            sr  <= sr >> 8;
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule
